pe_pool_arb: RTL
================

# pe_pool_arb

Round-robin burst arbiter that shares one PE_POOL instance (CNN PE followed by pooling and ReLU) among REQ_NUM requesters, such as tile loaders or layer schedulers. It grants the datapath for a whole burst of PE_IN_PACKETs and tags every issued packet in an in-order tag FIFO. It then steers each PE_OUT_PACKET from PE_POOL back to the requester that issued the matching input. It sits directly in front of and behind PE_POOL, which has no stall input and produces results in issue order.

## Interface
Parameters:
- DATA_WID, `CNN_XLEN, datapath word width, passed through to the packet types
- REQ_NUM, 4, number of requesters (2..8)
- TAG_B, 2, tag width; equals clog2(REQ_NUM)
- FIFO_DEPTH, 8, maximum packets in flight inside PE_POOL (power of 2)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low; all state clears while low
- req_pk  in  PE_IN_PACKET[REQ_NUM]  per-requester input packet
- req_valid  in  REQ_NUM  per-requester packet valid
- req_last  in  REQ_NUM  marks the final packet of a burst
- req_ready  out  REQ_NUM  per-requester accept
- pe_in_pk  out  PE_IN_PACKET  drives PE_POOL input; `.valid` qualifies it
- pe_out_pk  in  PE_OUT_PACKET  from PE_POOL; `.valid` qualifies it
- rsp_pk  out  PE_OUT_PACKET  result, broadcast to all requesters
- rsp_valid  out  REQ_NUM  one-hot owner of rsp_pk
- outstanding  out  clog2(FIFO_DEPTH)+1  tag FIFO occupancy
- busy  out  1  high when a burst is granted or outstanding ≠ 0
- err_orphan  out  1  sticky; set by a result arriving with the tag FIFO empty

## Operation
- FSM states: IDLE, BURST.
- **IDLE:**
  - All req_ready are 0.
  - If any req_valid is set, pick the first requester with req_valid set, scanning from rr_ptr upward modulo REQ_NUM.
  - Register that index as owner and go to BURST. Arbitration costs exactly one cycle.
- **BURST:**
  - req_ready[owner] = !fifo_full. All other req_ready are 0.
  - A handshake is req_valid[owner] & req_ready[owner]. On a handshake:
    - Register req_pk[owner] onto pe_in_pk with .valid = 1.
    - Push owner into the tag FIFO.
  - On a handshake with req_last[owner] = 1: set rr_ptr = (owner+1) mod REQ_NUM and return to IDLE.
  - A requester that drops req_valid mid-burst keeps the grant; the burst ends only on req_last.
- **Cycles without a handshake:** pe_in_pk is all-zero, including .valid = 0.
- **Return path:**
  - When pe_out_pk.valid = 1, pop the tag FIFO head t.
  - Next cycle: rsp_pk = pe_out_pk and rsp_valid = (1 << t).
  - There is no backpressure on the return path; requesters must sink results.
- **Orphan result:** pe_out_pk.valid with the FIFO empty sets err_orphan, produces no pop, and leaves rsp_valid = 0. err_orphan clears only on reset.
- **Push and pop in the same cycle:** occupancy is unchanged. req_ready is computed from the pre-pop full flag, so a full FIFO blocks issue that cycle even if a pop occurs.
- **Pointer wrap:** rr_ptr and the FIFO pointers wrap modulo REQ_NUM and FIFO_DEPTH.

## Timing
- **Reset values:**
  - pe_in_pk = 0
  - rsp_pk = 0
  - rsp_valid = 0
  - req_ready = 0
  - outstanding = 0
  - busy = 0
  - err_orphan = 0
  - state = IDLE
  - rr_ptr = 0
- **Reset asserted mid-burst:** in-flight tags are discarded. Results that PE_POOL emits after reset are treated as orphans.
- **Latency:**
  - req handshake at cycle n → pe_in_pk.valid at n+1.
  - pe_out_pk.valid at cycle m → rsp_valid at m+1.
- **Throughput within a burst:** 1 packet/cycle until the FIFO is full. A new grant reaches its first handshake at the earliest 1 cycle after entering IDLE.
- **Outputs:** all registered. req_ready is registered-state-derived: it depends only on state, owner and fifo_full.

## Structure
- Shared package (the existing CNN defines/package) holds:
  - PE_IN_PACKET and PE_OUT_PACKET, including their .valid fields
  - the ARB_STATE enum (IDLE, BURST)
  - the defaults for REQ_NUM and FIFO_DEPTH
- Sub-module tag_fifo: synchronous FIFO of width TAG_B and depth FIFO_DEPTH, with push, pop, head, full, empty and count. It is the one natural split; the arbiter and steering logic stay in pe_pool_arb.
- pe_pool_arb instantiates tag_fifo only. PE_POOL is instantiated alongside it by the parent.

## Test plan
- **Single burst:** requester 2 sends 3 packets, last on the 3rd. Required response:
  - grant 1 cycle after req_valid; pe_in_pk.valid on 3 consecutive cycles;
  - model PE_POOL returns at latency 5; rsp_valid = 4'b0100 three times; outstanding returns to 0.
- **Fairness:** all 4 requesters hold 1-packet bursts continuously. Required response: grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
- **Full FIFO:** requester 1 sends a 12-packet burst while the model PE_POOL has latency 20. Required response:
  - req_ready[1] drops after 8 handshakes and outstanding = 8;
  - issue resumes the cycle after the first pop; all 12 results route to rsp_valid[1].
- **Interleaved ownership:** bursts from requester 0 (2 packets) then requester 3 (2 packets), with PE_POOL latency 10. Required response: rsp_valid sequence 0001, 0001, 1000, 1000.
- **Orphan:** inject pe_out_pk.valid with no issue. Required response: err_orphan = 1 next cycle, rsp_valid = 0, outstanding stays 0.
- **Reset mid-burst:** assert reset low after 2 of 4 packets. Required response:
  - all outputs at reset values asynchronously;
  - after release, a new burst from requester 0 is granted first.

Source files
------------

// File: rtl/pe_pool_arb_pkg.sv
// Shared CNN packet types, arbiter state encoding and default sizing for the
// PE_POOL burst arbiter.
package pe_pool_arb_pkg;

  localparam int CNN_XLEN       = 16;
  localparam int REQ_NUM_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic                valid;
    logic [CNN_XLEN-1:0] act;
    logic [CNN_XLEN-1:0] wgt;
  } PE_IN_PACKET;

  typedef struct packed {
    logic                valid;
    logic [CNN_XLEN-1:0] result;
  } PE_OUT_PACKET;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ARB_STATE;

endpackage

// File: rtl/pe_pool_arb_tag_fifo.sv
// In-order FIFO holding the owner index of every packet issued into PE_POOL,
// so results can be steered back in issue order.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_pool_arb.sv
// Round-robin burst arbiter sharing one PE_POOL among REQ_NUM requesters and
// steering each in-order result back to the requester that issued it.
module pe_pool_arb
  import pe_pool_arb_pkg::*;
#(
  parameter int DATA_WID   = CNN_XLEN,
  parameter int REQ_NUM    = REQ_NUM_DEF,
  parameter int TAG_B      = $clog2(REQ_NUM),
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  PE_IN_PACKET [REQ_NUM-1:0]     req_pk,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM-1:0]            req_last,
  output logic [REQ_NUM-1:0]            req_ready,
  output PE_IN_PACKET                   pe_in_pk,
  input  PE_OUT_PACKET                  pe_out_pk,
  output PE_OUT_PACKET                  rsp_pk,
  output logic [REQ_NUM-1:0]            rsp_valid,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          busy,
  output logic                          err_orphan
);

  ARB_STATE         state;
  logic [TAG_B-1:0] owner;
  logic [TAG_B-1:0] rr_ptr;
  logic [TAG_B-1:0] next_ptr;
  logic [TAG_B-1:0] pick_idx;
  logic [TAG_B-1:0] scan_idx;
  logic [TAG_B-1:0] fifo_head;
  logic             pick_found;
  logic             fifo_full;
  logic             fifo_empty;
  logic             handshake;
  logic             do_pop;
  int               scan_sum;

  // First valid requester at or after rr_ptr, wrapping modulo REQ_NUM.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = 0;
    scan_idx   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      scan_sum = int'(rr_ptr) + i;
      if (scan_sum >= REQ_NUM) begin
        scan_sum = scan_sum - REQ_NUM;
      end
      scan_idx = TAG_B'(scan_sum);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST && !fifo_full) begin
      req_ready[owner] = 1'b1;
    end
  end

  assign handshake = req_valid[owner] & req_ready[owner];
  assign do_pop    = pe_out_pk.valid & ~fifo_empty;
  assign next_ptr  = (int'(owner) == REQ_NUM - 1) ? '0 : owner + 1'b1;
  assign busy      = (state == BURST) || (outstanding != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            state <= BURST;
          end
        end
        BURST: begin
          if (handshake && req_last[owner]) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue and return registers; both paths emit all-zero packets when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_in_pk   <= '0;
      rsp_pk     <= '0;
      rsp_valid  <= '0;
      err_orphan <= 1'b0;
    end else begin
      pe_in_pk <= '0;
      if (handshake) begin
        pe_in_pk       <= req_pk[owner];
        pe_in_pk.valid <= 1'b1;
      end
      rsp_pk    <= '0;
      rsp_valid <= '0;
      if (do_pop) begin
        rsp_pk.valid  <= 1'b1;
        rsp_pk.result <= pe_out_pk.result[DATA_WID-1:0];
        rsp_valid     <= REQ_NUM'(1) << fifo_head;
      end
      if (pe_out_pk.valid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  tag_fifo #(
    .WIDTH (TAG_B),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (handshake),
    .push_data (owner),
    .pop       (do_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule
